training_sequencer: RTL and testbench
=====================================

TRAINING_SEQUENCER -- requirements
Module: training_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 10, meaning features per sample (MAC and weight-update steps per sample).
REQ-002 SHALL have parameter NUM_SAMPLES, default 10, meaning samples per epoch.
REQ-003 SHALL have parameter IDX_W, default 4, meaning width of feat_idx and sample_idx; the design requires 2^IDX_W >= max(WIDTH, NUM_SAMPLES).
REQ-004 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, meaning reset, asynchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit, meaning a request to begin a training run; sampled only in IDLE.
REQ-007 SHALL have port num_epochs, input, 8 bits, meaning the epoch count; latched on the accepted start.
REQ-008 SHALL have port abort, input, 1 bit, meaning terminate the run.
REQ-009 SHALL have port dp_ack, input, 1 bit, meaning the datapath has completed the current step.
REQ-010 SHALL have port dp_req, output, 1 bit, meaning a datapath step is requested.
REQ-011 SHALL have port dp_op, output, 2 bits, meaning the step opcode: 00 MAC, 01 ERR, 10 UPD_W, 11 UPD_B.
REQ-012 SHALL have port feat_idx, output, IDX_W bits, meaning the current feature/weight index.
REQ-013 SHALL have port sample_idx, output, IDX_W bits, meaning the current sample index.
REQ-014 SHALL have port epoch_cnt, output, 8 bits, meaning the number of completed epochs.
REQ-015 SHALL have port acc_clr, output, 1 bit, meaning clear the prediction accumulator.
REQ-016 SHALL have port loss_clr, output, 1 bit, meaning clear the summed loss.
REQ-017 SHALL have port busy, output, 1 bit, meaning a run is in progress.
REQ-018 SHALL have port done, output, 1 bit, meaning a one-cycle pulse at normal run completion.

Function
REQ-019 SHALL implement states IDLE, CLEAR, FWD, ERR, UPD, BIAS, NEXT, DONE.
REQ-020 In IDLE, if start=1 and num_epochs!=0, SHALL latch num_epochs, zero all indices and epoch_cnt, and go to CLEAR.
REQ-021 In IDLE, if start=1 and num_epochs=0, SHALL go directly to DONE.
REQ-022 A datapath step SHALL complete in any cycle where dp_req=1 and dp_ack=1; dp_op, feat_idx and sample_idx SHALL be held stable while dp_req=1 and dp_ack=0.
REQ-023 In CLEAR, SHALL drive dp_req=0 and acc_clr=1, SHALL also drive loss_clr=1 when sample_idx=0, and SHALL go to FWD with feat_idx=0 after exactly one cycle.
REQ-024 In FWD, SHALL drive dp_req=1 and dp_op=00; on completion, SHALL increment feat_idx, or, when feat_idx=WIDTH-1, SHALL clear feat_idx and go to ERR.
REQ-025 In ERR, SHALL drive dp_req=1 and dp_op=01; on completion, SHALL go to UPD.
REQ-026 In UPD, SHALL drive dp_req=1 and dp_op=10; on completion, SHALL increment feat_idx, or, when feat_idx=WIDTH-1, SHALL clear feat_idx and go to BIAS.
REQ-027 In BIAS, SHALL drive dp_req=1 and dp_op=11; on completion, SHALL go to NEXT.
REQ-028 In NEXT (one cycle, dp_req=0), if sample_idx<NUM_SAMPLES-1, SHALL increment sample_idx and go to CLEAR.
REQ-029 In NEXT, if sample_idx=NUM_SAMPLES-1, SHALL wrap sample_idx to 0 and increment epoch_cnt, then go to DONE if the new epoch_cnt equals the latched epoch count, else go to CLEAR.
REQ-030 In DONE, SHALL drive done=1 for exactly one cycle and then go to IDLE; epoch_cnt SHALL hold its final value until the next accepted start.
REQ-031 busy SHALL be 1 in every state except IDLE; start SHALL be ignored while busy=1.
REQ-032 dp_req, acc_clr and loss_clr SHALL be 0 in IDLE, NEXT and DONE.
REQ-033 Per-sample cost SHALL be 2*WIDTH+4 cycles when dp_ack is tied high (24 cycles at the defaults).
REQ-034 abort=1 while busy SHALL force IDLE at the next edge, deassert dp_req, and produce no done pulse; abort SHALL take priority over a simultaneous dp_ack.
REQ-035 A dp_ack received while dp_req=0 SHALL be ignored.
REQ-036 Index counters SHALL never exceed WIDTH-1 or NUM_SAMPLES-1; epoch_cnt SHALL never exceed the latched epoch count.

Reset
REQ-037 While reset=0, asynchronously, the block SHALL enter IDLE with all outputs 0, feat_idx=0, sample_idx=0, epoch_cnt=0 and the latched epoch count 0.
REQ-038 Reset asserted mid-run SHALL abandon the run with no done pulse; the first accepted start after reset release SHALL begin a fresh run.

Verification
REQ-039 dp_ack tied 1, num_epochs=1, start pulse -> done exactly 240 cycles after the start-sampling edge, epoch_cnt=1, and 100 MAC, 10 ERR, 100 UPD_W, 10 UPD_B steps counted.
REQ-040 dp_ack random with 50% probability, num_epochs=3 -> opcode/index sequence identical to the ack-tied case, no index change while dp_req=1 and dp_ack=0, epoch_cnt=3 at done.
REQ-041 num_epochs=0 with start -> busy high for one cycle, done pulse, no dp_req ever asserted.
REQ-042 abort asserted on the 5th UPD_W step together with dp_ack=1 -> IDLE next cycle, busy=0, no done pulse; a following start runs normally.
REQ-043 reset driven low mid-FWD at sample 4, released, then start with num_epochs=2 -> all outputs 0 during reset, and the new run starts from sample 0 with loss_clr on its first CLEAR.
REQ-044 start held high continuously during a run -> no restart while busy; a new run begins the cycle after done.

Source files
------------

// File: rtl/training_sequencer.sv
// Step sequencer for a single-layer trainer: per sample it clears the accumulator,
// issues WIDTH MACs, one error step, WIDTH weight updates and one bias update.
module training_sequencer #(
    parameter int WIDTH       = 10,
    parameter int NUM_SAMPLES = 10,
    parameter int IDX_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       num_epochs,
    input  logic             abort,
    input  logic             dp_ack,
    output logic             dp_req,
    output logic [1:0]       dp_op,
    output logic [IDX_W-1:0] feat_idx,
    output logic [IDX_W-1:0] sample_idx,
    output logic [7:0]       epoch_cnt,
    output logic             acc_clr,
    output logic             loss_clr,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FWD   = 3'd2;
    localparam logic [2:0] S_ERR   = 3'd3;
    localparam logic [2:0] S_UPD   = 3'd4;
    localparam logic [2:0] S_BIAS  = 3'd5;
    localparam logic [2:0] S_NEXT  = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    localparam logic [IDX_W-1:0] FEAT_LAST = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] SAMP_LAST = IDX_W'(NUM_SAMPLES - 1);

    logic [2:0]       state_q, state_d;
    logic [IDX_W-1:0] feat_q, feat_d;
    logic [IDX_W-1:0] samp_q, samp_d;
    logic [7:0]       epc_q, epc_d;
    logic [7:0]       epochs_q, epochs_d;
    logic             step_done;

    assign dp_req    = (state_q == S_FWD) || (state_q == S_ERR) ||
                       (state_q == S_UPD) || (state_q == S_BIAS);
    assign step_done = dp_req && dp_ack;

    always_comb begin
        dp_op = 2'b00;
        case (state_q)
            S_ERR:   dp_op = 2'b01;
            S_UPD:   dp_op = 2'b10;
            S_BIAS:  dp_op = 2'b11;
            default: dp_op = 2'b00;
        endcase
    end

    assign feat_idx   = feat_q;
    assign sample_idx = samp_q;
    assign epoch_cnt  = epc_q;
    assign acc_clr    = (state_q == S_CLEAR);
    assign loss_clr   = (state_q == S_CLEAR) && (samp_q == '0);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);

    always_comb begin
        state_d  = state_q;
        feat_d   = feat_q;
        samp_d   = samp_q;
        epc_d    = epc_q;
        epochs_d = epochs_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_epochs != 8'd0) begin
                        epochs_d = num_epochs;
                        feat_d   = '0;
                        samp_d   = '0;
                        epc_d    = 8'd0;
                        state_d  = S_CLEAR;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_CLEAR: begin
                feat_d  = '0;
                state_d = S_FWD;
            end
            S_FWD: begin
                if (step_done) begin
                    if (feat_q == FEAT_LAST) begin
                        feat_d  = '0;
                        state_d = S_ERR;
                    end else begin
                        feat_d = feat_q + 1'b1;
                    end
                end
            end
            S_ERR: begin
                if (step_done) state_d = S_UPD;
            end
            S_UPD: begin
                if (step_done) begin
                    if (feat_q == FEAT_LAST) begin
                        feat_d  = '0;
                        state_d = S_BIAS;
                    end else begin
                        feat_d = feat_q + 1'b1;
                    end
                end
            end
            S_BIAS: begin
                if (step_done) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (samp_q != SAMP_LAST) begin
                    samp_d  = samp_q + 1'b1;
                    state_d = S_CLEAR;
                end else begin
                    samp_d  = '0;
                    epc_d   = epc_q + 8'd1;
                    state_d = (epc_d == epochs_q) ? S_DONE : S_CLEAR;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort wins over any step completing in the same cycle: nothing advances.
        if (abort && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            feat_d   = feat_q;
            samp_d   = samp_q;
            epc_d    = epc_q;
            epochs_d = epochs_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            feat_q   <= '0;
            samp_q   <= '0;
            epc_q    <= 8'd0;
            epochs_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            feat_q   <= feat_d;
            samp_q   <= samp_d;
            epc_q    <= epc_d;
            epochs_q <= epochs_d;
        end
    end

endmodule

// File: tb/tb_training_sequencer.sv
// Directed/randomized bench for training_sequencer; expected step stream is
// generated from nested epoch/sample/feature loops and compared at each handshake.
module tb_training_sequencer;

    localparam int WIDTH = 10;
    localparam int NS    = 10;

    logic       clk = 1'b0;
    logic       reset, start, abort, dp_ack;
    logic [7:0] num_epochs;
    logic       dp_req, acc_clr, loss_clr, busy, done;
    logic [1:0] dp_op;
    logic [3:0] feat_idx, sample_idx;
    logic [7:0] epoch_cnt;

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] f;
        logic [3:0] s;
    } step_t;

    step_t exp_q[$];
    int    cnt[4];
    int    checks   = 0;
    int    failures = 0;
    int    dk;

    training_sequencer #(.WIDTH(WIDTH), .NUM_SAMPLES(NS), .IDX_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .num_epochs(num_epochs),
        .abort(abort), .dp_ack(dp_ack), .dp_req(dp_req), .dp_op(dp_op),
        .feat_idx(feat_idx), .sample_idx(sample_idx), .epoch_cnt(epoch_cnt),
        .acc_clr(acc_clr), .loss_clr(loss_clr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void build(input int epochs);
        exp_q.delete();
        for (int e = 0; e < epochs; e++)
            for (int s = 0; s < NS; s++) begin
                for (int f = 0; f < WIDTH; f++) exp_q.push_back('{2'd0, 4'(f), 4'(s)});
                exp_q.push_back('{2'd1, 4'd0, 4'(s)});
                for (int f = 0; f < WIDTH; f++) exp_q.push_back('{2'd2, 4'(f), 4'(s)});
                exp_q.push_back('{2'd3, 4'd0, 4'(s)});
            end
    endfunction

    task automatic start_run(input logic [7:0] n, input bit hold);
        @(negedge clk);
        dp_ack     = 1'b0;
        start      = 1'b1;
        num_epochs = n;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    // Iteration k samples the state left by the k-th edge after the start-sampling edge.
    task automatic run(input int epochs, input bit rnd, input int abort_upd, output int done_k);
        logic       p_req, p_ack;
        logic [9:0] p_sig;
        bit         ack;
        int         upd_n, limit;
        step_t      e;
        build(epochs);
        cnt    = '{default: 0};
        done_k = -1;
        upd_n  = 0;
        p_req  = 1'b0;
        p_ack  = 1'b0;
        p_sig  = '0;
        limit  = rnd ? 1200 * epochs + 50 : 260 * epochs + 10;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (done) begin
                done_k = k;
                chk("done_no_req", dp_req, 1'b0);
                break;
            end
            if (!busy) break;
            if (dp_req && p_req && !p_ack) chk("hold", {dp_op, feat_idx, sample_idx}, p_sig);
            e = (exp_q.size() != 0) ? exp_q[0] : '1;
            if (acc_clr) begin
                chk("clr_sample", sample_idx, e.s);
                chk("loss_clr", loss_clr, 32'(e.s == 4'd0));
            end
            ack   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            abort = 1'b0;
            if (dp_req && ack) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
                chk("step", {dp_op, feat_idx, sample_idx}, e);
                cnt[dp_op]++;
                if (dp_op == 2'd2) begin
                    upd_n++;
                    if (upd_n == abort_upd) abort = 1'b1;
                end
            end
            dp_ack = ack;
            p_req  = dp_req;
            p_ack  = ack;
            p_sig  = {dp_op, feat_idx, sample_idx};
        end
        dp_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; dp_ack = 1'b0; num_epochs = 8'd0;
        #12;
        chk("reset_outs", {dp_req, dp_op, feat_idx, sample_idx, epoch_cnt, acc_clr, loss_clr, busy, done}, 0);
        @(negedge clk);
        reset = 1'b1;

        // Single epoch, ack tied high: 24 cycles per sample.
        start_run(8'd1, 1'b0);
        run(1, 1'b0, 0, dk);
        chk("lat_1ep", dk, 240);
        chk("epoch_1", epoch_cnt, 1);
        chk("n_mac", cnt[0], 100);
        chk("n_err", cnt[1], 10);
        chk("n_updw", cnt[2], 100);
        chk("n_updb", cnt[3], 10);
        chk("q_empty1", exp_q.size(), 0);
        @(negedge clk);
        chk("idle_after_done", {busy, done}, 0);
        chk("epoch_hold", epoch_cnt, 1);

        // Random ack, three epochs.
        start_run(8'd3, 1'b0);
        run(3, 1'b1, 0, dk);
        chk("rnd_done_seen", 32'(dk >= 720), 1);
        chk("epoch_3", epoch_cnt, 3);
        chk("q_empty3", exp_q.size(), 0);

        // Zero epochs.
        start_run(8'd0, 1'b0);
        @(negedge clk);
        chk("zero_busy_done", {busy, done, dp_req}, 3'b110);
        @(negedge clk);
        chk("zero_after", {busy, done, dp_req}, 3'b000);

        // Abort on the 5th weight update together with ack.
        start_run(8'd1, 1'b0);
        run(1, 1'b0, 5, dk);
        abort = 1'b0;
        chk("abort_no_done", dk, 32'(-1));
        chk("abort_idle", {busy, dp_req, done}, 3'b000);
        chk("abort_updw_cnt", cnt[2], 5);
        start_run(8'd1, 1'b0);
        run(1, 1'b1, 0, dk);
        chk("post_abort_run", 32'(dk >= 240), 1);
        chk("post_abort_ep", epoch_cnt, 1);

        // Reset in the middle of FWD at sample 4.
        start_run(8'd2, 1'b0);
        dp_ack = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (dp_req && dp_op == 2'd0 && sample_idx == 4'd4) break;
        end
        chk("reach_s4", {dp_req, dp_op, sample_idx}, {1'b1, 2'd0, 4'd4});
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_outs", {dp_req, dp_op, feat_idx, sample_idx, epoch_cnt, acc_clr, loss_clr, busy, done}, 0);
        dp_ack = 1'b0;
        @(negedge clk);
        chk("rst_hold_outs", {dp_req, dp_op, feat_idx, sample_idx, epoch_cnt, acc_clr, loss_clr, busy, done}, 0);
        reset = 1'b1;
        start_run(8'd2, 1'b0);
        run(2, 1'b0, 0, dk);
        chk("lat_2ep", dk, 480);
        chk("epoch_2", epoch_cnt, 2);

        // Start held high through a run.
        start_run(8'd1, 1'b1);
        run(1, 1'b0, 0, dk);
        chk("held_lat", dk, 240);
        @(negedge clk);
        chk("held_idle", busy, 0);
        @(negedge clk);
        chk("held_restart", {busy, acc_clr, loss_clr, sample_idx, epoch_cnt}, {3'b111, 4'd0, 8'd0});
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("held_abort", {busy, done}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
